// File: rtl/sdnet_to_mtpsa.sv
// SDNet-to-SUME adapter: pairs each packet with one queued metadata tuple.
// Ports: s_axis packet in, tuple_in strobe, m_axis packet+tuser out, status.
module sdnet_to_mtpsa #(
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int C_TUSER_WIDTH     = 304,
  parameter int TUPLE_FIFO_DEPTH  = 4
) (
  input  logic                           axis_aclk,
  input  logic                           axis_rst,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic                           tuple_in_VALID,
  input  logic [C_TUSER_WIDTH-1:0]       tuple_in_DATA,
  output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [C_TUSER_WIDTH-1:0]       m_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           tuple_overflow,
  output logic [31:0]                    pkt_count,
  output logic [15:0]                    tuple_drop_count
);

  localparam int AW = $clog2(TUPLE_FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] IN_PKT = 1'b1;

  logic [0:0] state;

  logic [C_TUSER_WIDTH-1:0] mem [TUPLE_FIFO_DEPTH];

  // Extra MSB on each pointer separates full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic fifo_empty;
  logic fifo_full;
  logic accept;
  logic pop;
  logic push;
  logic drop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_comb begin
    m_axis_tvalid = 1'b0;
    s_axis_tready = 1'b0;
    if (!axis_rst) begin
      unique case (state)
        IDLE: begin
          m_axis_tvalid = s_axis_tvalid & ~fifo_empty;
          s_axis_tready = m_axis_tready & ~fifo_empty;
        end
        IN_PKT: begin
          m_axis_tvalid = s_axis_tvalid;
          s_axis_tready = m_axis_tready;
        end
        default: begin
          m_axis_tvalid = 1'b0;
          s_axis_tready = 1'b0;
        end
      endcase
    end
  end

  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tkeep = s_axis_tkeep;
  assign m_axis_tlast = s_axis_tlast;

  // Only non-empty when valid, so an unwritten slot is never exposed.
  assign m_axis_tuser = m_axis_tvalid ? mem[rd_ptr[AW-1:0]] : '0;

  assign accept = m_axis_tvalid & m_axis_tready;
  assign pop    = accept & s_axis_tlast;
  // A pop in the same cycle frees a slot for a tuple arriving on a full FIFO.
  assign push   = tuple_in_VALID & (~fifo_full | pop);
  assign drop   = tuple_in_VALID & fifo_full & ~pop;

  always_ff @(posedge axis_aclk) begin
    if (push && !axis_rst) begin
      mem[wr_ptr[AW-1:0]] <= tuple_in_DATA;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      tuple_overflow   <= 1'b0;
      pkt_count        <= '0;
      tuple_drop_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        pkt_count <= pkt_count + 32'd1;
      end
      if (drop) begin
        tuple_overflow <= 1'b1;
        if (tuple_drop_count != 16'hFFFF) begin
          tuple_drop_count <= tuple_drop_count + 16'd1;
        end
      end
      if (accept) begin
        state <= s_axis_tlast ? IDLE : IN_PKT;
      end
    end
  end

endmodule

// File: tb/tb_sdnet_to_mtpsa.sv
// Directed bench for sdnet_to_mtpsa: tuple/packet pairing, stalls, reset.
// Drives after each rising edge, checks mid-cycle.
module tb_sdnet_to_mtpsa;

  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int UW = 304;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic          t_valid;
  logic [UW-1:0] t_data;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          ovf;
  logic [31:0]   pkts;
  logic [15:0]   drops;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sdnet_to_mtpsa dut (
    .axis_aclk        (clk),
    .axis_rst         (rst),
    .s_axis_tdata     (s_tdata),
    .s_axis_tkeep     (s_tkeep),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tready    (s_tready),
    .s_axis_tlast     (s_tlast),
    .tuple_in_VALID   (t_valid),
    .tuple_in_DATA    (t_data),
    .m_axis_tdata     (m_tdata),
    .m_axis_tkeep     (m_tkeep),
    .m_axis_tuser     (m_tuser),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tready    (m_tready),
    .m_axis_tlast     (m_tlast),
    .tuple_overflow   (ovf),
    .pkt_count        (pkts),
    .tuple_drop_count (drops)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [319:0] obs,
                     input logic [319:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic beat(input logic [31:0] tag, input logic last);
    s_tvalid = 1'b1;
    s_tdata  = {8{tag}};
    s_tkeep  = {KW{1'b1}};
    s_tlast  = last;
  endtask

  task automatic strobe(input logic [31:0] v);
    t_valid = 1'b1;
    t_data  = UW'(v);
  endtask

  initial begin
    int beats;
    rst      = 1'b1;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    t_valid  = 1'b0;
    t_data   = '0;
    m_tready = 1'b0;

    // Reset: outputs gated off, counters cleared.
    tick();
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    settle();
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_sready", s_tready, 0);
    chk("rst_tuser", m_tuser, 0);
    tick();
    rst = 1'b0;
    s_tvalid = 1'b0;
    settle();
    chk("rst_pkts", pkts, 0);
    chk("rst_drops", drops, 0);
    chk("rst_ovf", ovf, 0);

    // 3-beat packet with tuple 0xA5; no bypass in strobe cycle.
    tick();
    strobe(32'hA5);
    beat(32'hB0, 1'b0);
    s_tkeep = 32'h0000_FFFF;
    settle();
    chk("a5_nobypass", m_tvalid, 0);
    tick();
    t_valid = 1'b0;
    settle();
    chk("a5_b0_valid", m_tvalid, 1);
    chk("a5_b0_tuser", m_tuser, 32'hA5);
    chk("a5_b0_tdata", m_tdata, {8{32'hB0}});
    chk("a5_b0_tkeep", m_tkeep, 32'h0000_FFFF);
    tick();
    beat(32'hB1, 1'b0);
    settle();
    chk("a5_b1_tuser", m_tuser, 32'hA5);
    tick();
    beat(32'hB2, 1'b1);
    settle();
    chk("a5_b2_tuser", m_tuser, 32'hA5);
    chk("a5_b2_tlast", m_tlast, 1);
    tick();
    beat(32'hC0, 1'b1);
    settle();
    chk("a5_pkts", pkts, 1);
    chk("a5_empty_mvalid", m_tvalid, 0);

    // No tuple: beat blocked for 10 cycles, then released.
    for (int i = 0; i < 10; i++) begin
      chk("blk_sready", s_tready, 0);
      chk("blk_mvalid", m_tvalid, 0);
      tick();
    end
    chk("blk_tuser0", m_tuser, 0);
    strobe(32'h11);
    settle();
    chk("blk_strobe_cyc", m_tvalid, 0);
    tick();
    t_valid = 1'b0;
    settle();
    chk("blk_release", m_tvalid, 1);
    chk("blk_rel_tuser", m_tuser, 32'h11);
    chk("blk_rel_sready", s_tready, 1);
    tick();
    s_tvalid = 1'b0;
    settle();
    chk("blk_pkts", pkts, 2);

    // Five tuples into a 4-deep FIFO: one dropped.
    for (int i = 1; i <= 5; i++) begin
      strobe(i);
      tick();
    end
    t_valid = 1'b0;
    settle();
    chk("ovf_flag", ovf, 1);
    chk("ovf_drops", drops, 1);
    for (int i = 1; i <= 4; i++) begin
      beat(32'hD0 + i, 1'b1);
      settle();
      chk("ovf_order", m_tuser, i);
      tick();
    end
    s_tvalid = 1'b1;
    settle();
    chk("ovf_drained", m_tvalid, 0);
    chk("ovf_pkts", pkts, 6);
    s_tvalid = 1'b0;

    // Full FIFO: strobe together with tlast pop is kept.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      strobe(32'h20 + i);
      tick();
    end
    strobe(32'h25);
    beat(32'hE0, 1'b1);
    settle();
    chk("full_head", m_tuser, 32'h21);
    tick();
    s_tvalid = 1'b0;
    strobe(32'h26);
    settle();
    chk("full_ovf0", ovf, 0);
    chk("full_drops0", drops, 0);
    chk("full_pkts", pkts, 1);
    tick();
    t_valid = 1'b0;
    settle();
    chk("full_still", drops, 1);
    for (int i = 2; i <= 5; i++) begin
      beat(32'hE0 + i, 1'b1);
      settle();
      chk("full_order", m_tuser, 32'h20 + i);
      tick();
    end
    s_tvalid = 1'b0;
    settle();
    chk("full_pkts2", pkts, 5);

    // 4-beat packet with ready toggling.
    strobe(32'h31);
    tick();
    t_valid = 1'b0;
    beats = 0;
    for (int b = 0; b < 4; b++) begin
      beat(32'hF0 + b, b == 3);
      m_tready = 1'b0;
      settle();
      chk("stall_valid", m_tvalid, 1);
      chk("stall_sready", s_tready, 0);
      if (m_tvalid && m_tready) beats++;
      tick();
      m_tready = 1'b1;
      settle();
      chk("stall_tdata", m_tdata, {8{32'hF0 + b}});
      chk("stall_tuser", m_tuser, 32'h31);
      chk("stall_tlast", m_tlast, b == 3);
      if (m_tvalid && m_tready) beats++;
      tick();
    end
    chk("stall_beats", beats, 4);
    chk("stall_pkts", pkts, 6);
    beat(32'hAA, 1'b0);
    settle();
    chk("stall_popped", m_tvalid, 0);

    // Reset after two beats of a 4-beat packet.
    s_tvalid = 1'b0;
    strobe(32'h41);
    tick();
    t_valid = 1'b0;
    beat(32'h50, 1'b0);
    tick();
    beat(32'h51, 1'b0);
    tick();
    rst = 1'b1;
    beat(32'h52, 1'b0);
    tick();
    rst = 1'b0;
    settle();
    chk("mid_pkts", pkts, 0);
    chk("mid_ovf", ovf, 0);
    chk("mid_blk_valid", m_tvalid, 0);
    chk("mid_blk_ready", s_tready, 0);
    tick();
    chk("mid_blk_valid2", m_tvalid, 0);
    beat(32'h60, 1'b1);
    strobe(32'h42);
    tick();
    t_valid = 1'b0;
    settle();
    chk("mid_new_valid", m_tvalid, 1);
    chk("mid_new_tuser", m_tuser, 32'h42);
    tick();
    s_tvalid = 1'b0;
    settle();
    chk("mid_new_pkts", pkts, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
